// File: rtl/line_buf_wr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : line_buf_wr_ctrl_pkg
//  Brief    : Shared types and helpers for the multi-page line-buffer write
//             controller (FSM encoding, width helpers, line error function).
//  Revision : 1.0 - initial release
// ============================================================================
package line_buf_wr_ctrl_pkg;

    // Write-side FSM: idle until a frame starts, collect pixels, or discard a
    // line that found every page occupied.
    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        DROP       = 2'd2
    } lbw_state_t;

    // Number of pages in the ring for a given page index width.
    function automatic int unsigned pages_f(input int unsigned page_w);
        return 32'd1 << page_w;
    endfunction

    // Full DPRAM write address width: {page, pixel index}.
    function automatic int unsigned wr_addr_w_f(input int unsigned addr_w,
                                                input int unsigned page_w);
        return addr_w + page_w;
    endfunction

    // Pixel counter width: one extra bit so a full page (2^addr_w) is
    // representable as a line length.
    function automatic int unsigned len_w_f(input int unsigned addr_w);
        return addr_w + 32'd1;
    endfunction

    // A committed line is bad if any pixel was corrupt or the page overran
    // (both folded into flag), or if its length differs from the expected
    // length when a length check is enabled (line_len != 0).
    function automatic logic line_err_f(input logic        flag,
                                        input int unsigned count,
                                        input int unsigned line_len);
        return flag | ((line_len != 32'd0) && (count != line_len));
    endfunction

endpackage : line_buf_wr_ctrl_pkg
`default_nettype wire

// File: rtl/line_page_ring.sv
`default_nettype none
// ============================================================================
//  Module   : line_page_ring
//  Brief    : Write-page pointer plus committed-page occupancy counter for the
//             line buffer. Commits advance the pointer and occupancy; read-side
//             releases decrement occupancy.
//  Revision : 1.0 - initial release
// ============================================================================
module line_page_ring
    import line_buf_wr_ctrl_pkg::*;
#(
    parameter int unsigned C_PAGE_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [C_PAGE_W-1:0] o_wr_page,
    output logic [C_PAGE_W:0]   o_occupancy,
    output logic                o_full
);

    logic [C_PAGE_W-1:0] r_wr_page;
    logic [C_PAGE_W:0]   r_occ;
    logic                w_dec_ok;

    // A release with nothing committed is meaningless and is ignored.
    assign w_dec_ok = i_dec && (r_occ != '0);

    // Page pointer wraps naturally because the page count is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_page <= '0;
        end else if (i_inc) begin
            r_wr_page <= r_wr_page + 1'b1;
        end
    end

    // Occupancy up/down counter; a simultaneous commit and release cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({i_inc, w_dec_ok})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_wr_page   = r_wr_page;
    assign o_occupancy = r_occ;
    assign o_full      = (32'(r_occ) == pages_f(C_PAGE_W));

endmodule : line_page_ring
`default_nettype wire

// File: rtl/line_buf_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : line_buf_wr_ctrl
//  Brief    : Multi-page line-buffer write controller for the NanEye receive
//             path. Writes deserialized pixels into one of 2^C_PAGE_W DPRAM
//             pages, reports each committed line (page, length, error) and
//             drops lines that arrive while every page is occupied.
//  Revision : 1.0 - initial release
// ============================================================================
module line_buf_wr_ctrl
    import line_buf_wr_ctrl_pkg::*;
#(
    parameter int unsigned C_ADDR_W   = 9,
    parameter int unsigned C_PAGE_W   = 1,
    parameter int unsigned C_DATA_W   = 10,
    parameter int unsigned C_LINE_LEN = 250
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         PULSE,
    input  logic [C_DATA_W-1:0]          PIXEL_DATA,
    input  logic                         PIXEL_ERROR,
    input  logic                         LINE_SYNC,
    input  logic                         FRAME_SYNC,
    input  logic                         RD_DONE,
    output logic [C_PAGE_W+C_ADDR_W-1:0] DPRAM_WR_ADDR,
    output logic [C_DATA_W-1:0]          DPRAM_WR_DATA,
    output logic                         DPRAM_WE,
    output logic                         LINE_FINISHED,
    output logic [C_PAGE_W-1:0]          LINE_PAGE,
    output logic [C_ADDR_W:0]            LINE_LEN,
    output logic                         LINE_ERR,
    output logic                         OVERFLOW,
    output logic [C_PAGE_W:0]            OCCUPANCY
);

    localparam int unsigned c_wr_addr_w = wr_addr_w_f(C_ADDR_W, C_PAGE_W);
    localparam int unsigned c_len_w     = len_w_f(C_ADDR_W);

    // Page capacity expressed in counter width: 2^C_ADDR_W.
    localparam logic [c_len_w-1:0] c_page_cap = {1'b1, {C_ADDR_W{1'b0}}};
    localparam logic [c_len_w-1:0] c_one      = {{C_ADDR_W{1'b0}}, 1'b1};

    // FSM and line accumulation state
    lbw_state_t              r_state,  w_state_nxt;
    logic [c_len_w-1:0]      r_count,  w_count_nxt;
    logic                    r_err,    w_err_nxt;

    // Line state after accounting for a pixel arriving this cycle
    logic [c_len_w-1:0]      w_pix_count;
    logic                    w_pix_err;

    // Registered outputs and their next values
    logic                    r_we,     w_we_nxt;
    logic [c_wr_addr_w-1:0]  r_addr,   w_addr_nxt;
    logic [C_DATA_W-1:0]     r_data,   w_data_nxt;
    logic                    r_fin,    w_fin_nxt;
    logic [C_PAGE_W-1:0]     r_lpage,  w_lpage_nxt;
    logic [c_len_w-1:0]      r_llen,   w_llen_nxt;
    logic                    r_lerr,   w_lerr_nxt;
    logic                    r_ovf,    w_ovf_nxt;

    // Page ring interface
    logic                    w_commit;
    logic [C_PAGE_W-1:0]     w_wr_page;
    logic [C_PAGE_W:0]       w_occ;
    logic                    w_full;

    line_page_ring #(
        .C_PAGE_W (C_PAGE_W)
    ) u_page_ring (
        .clk         (CLOCK),
        .rst         (RESET),
        .i_inc       (w_commit),
        .i_dec       (RD_DONE),
        .o_wr_page   (w_wr_page),
        .o_occupancy (w_occ),
        .o_full      (w_full)
    );

    // Next-state, pixel write, commit and drop decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_err_nxt   = r_err;
        w_pix_count = r_count;
        w_pix_err   = r_err;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_fin_nxt   = 1'b0;
        w_lpage_nxt = r_lpage;
        w_llen_nxt  = r_llen;
        w_lerr_nxt  = r_lerr;
        w_ovf_nxt   = 1'b0;
        w_commit    = 1'b0;

        if (FRAME_SYNC) begin
            // Frame start overrides everything: partial line and any pixel
            // on this cycle are discarded, the write page is kept.
            w_state_nxt = ACTIVE;
            w_count_nxt = '0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                WAIT_FRAME: begin
                    // Pixels and line syncs before the first frame are ignored.
                end

                ACTIVE: begin
                    if (PULSE) begin
                        if ((r_count == '0) && w_full) begin
                            // No free page for a new line: discard the line.
                            w_state_nxt = DROP;
                        end else if (r_count < c_page_cap) begin
                            w_we_nxt    = 1'b1;
                            w_addr_nxt  = {w_wr_page, r_count[C_ADDR_W-1:0]};
                            w_data_nxt  = PIXEL_DATA;
                            w_pix_count = r_count + c_one;
                            w_pix_err   = r_err | PIXEL_ERROR;
                        end else begin
                            // Page overrun: pixel lost, count saturates.
                            w_pix_err   = 1'b1;
                        end
                    end

                    w_count_nxt = w_pix_count;
                    w_err_nxt   = w_pix_err;

                    if (LINE_SYNC) begin
                        if (w_state_nxt == DROP) begin
                            // Line began and ended in the same cycle while full.
                            w_state_nxt = ACTIVE;
                            w_ovf_nxt   = 1'b1;
                            w_count_nxt = '0;
                            w_err_nxt   = 1'b0;
                        end else if (w_pix_count != '0) begin
                            // A pixel on this cycle is counted before the commit.
                            w_fin_nxt   = 1'b1;
                            w_lpage_nxt = w_wr_page;
                            w_llen_nxt  = w_pix_count;
                            w_lerr_nxt  = line_err_f(w_pix_err, 32'(w_pix_count),
                                                     C_LINE_LEN);
                            w_commit    = 1'b1;
                            w_count_nxt = '0;
                            w_err_nxt   = 1'b0;
                        end
                    end
                end

                DROP: begin
                    if (LINE_SYNC) begin
                        w_state_nxt = ACTIVE;
                        w_ovf_nxt   = 1'b1;
                        w_count_nxt = '0;
                        w_err_nxt   = 1'b0;
                    end
                end

                default: begin
                    w_state_nxt = WAIT_FRAME;
                end
            endcase
        end
    end

    // State and output registers; reset clears every output and the line.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= WAIT_FRAME;
            r_count <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_fin   <= 1'b0;
            r_lpage <= '0;
            r_llen  <= '0;
            r_lerr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_fin   <= w_fin_nxt;
            r_lpage <= w_lpage_nxt;
            r_llen  <= w_llen_nxt;
            r_lerr  <= w_lerr_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign DPRAM_WE      = r_we;
    assign DPRAM_WR_ADDR = r_addr;
    assign DPRAM_WR_DATA = r_data;
    assign LINE_FINISHED = r_fin;
    assign LINE_PAGE     = r_lpage;
    assign LINE_LEN      = r_llen;
    assign LINE_ERR      = r_lerr;
    assign OVERFLOW      = r_ovf;
    assign OCCUPANCY     = w_occ;

endmodule : line_buf_wr_ctrl
`default_nettype wire

// File: tb/tb_line_buf_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_buf_wr_ctrl
//  Brief    : Directed self-checking bench for line_buf_wr_ctrl with four
//             pages of 512 pixels and a 250-pixel expected line length.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_buf_wr_ctrl;

    localparam int A_W = 9;
    localparam int P_W = 2;
    localparam int D_W = 10;
    localparam int LL  = 250;

    logic               CLOCK_tb = 1'b0;
    logic               RESET;
    logic               PULSE;
    logic [D_W-1:0]     PIXEL_DATA;
    logic               PIXEL_ERROR;
    logic               LINE_SYNC;
    logic               FRAME_SYNC;
    logic               RD_DONE;
    logic [P_W+A_W-1:0] DPRAM_WR_ADDR;
    logic [D_W-1:0]     DPRAM_WR_DATA;
    logic               DPRAM_WE;
    logic               LINE_FINISHED;
    logic [P_W-1:0]     LINE_PAGE;
    logic [A_W:0]       LINE_LEN;
    logic               LINE_ERR;
    logic               OVERFLOW;
    logic [P_W:0]       OCCUPANCY;

    int n_checks = 0;
    int n_errors = 0;

    // Write monitor state
    logic [P_W+A_W-1:0] wr_log [0:4095];
    int wr_total     = 0;
    int bad_data     = 0;
    int commit_total = 0;
    int base;
    int cbase;

    line_buf_wr_ctrl #(
        .C_ADDR_W   (A_W),
        .C_PAGE_W   (P_W),
        .C_DATA_W   (D_W),
        .C_LINE_LEN (LL)
    ) dut (
        .CLOCK         (CLOCK_tb),
        .RESET         (RESET),
        .PULSE         (PULSE),
        .PIXEL_DATA    (PIXEL_DATA),
        .PIXEL_ERROR   (PIXEL_ERROR),
        .LINE_SYNC     (LINE_SYNC),
        .FRAME_SYNC    (FRAME_SYNC),
        .RD_DONE       (RD_DONE),
        .DPRAM_WR_ADDR (DPRAM_WR_ADDR),
        .DPRAM_WR_DATA (DPRAM_WR_DATA),
        .DPRAM_WE      (DPRAM_WE),
        .LINE_FINISHED (LINE_FINISHED),
        .LINE_PAGE     (LINE_PAGE),
        .LINE_LEN      (LINE_LEN),
        .LINE_ERR      (LINE_ERR),
        .OVERFLOW      (OVERFLOW),
        .OCCUPANCY     (OCCUPANCY)
    );

    always #5 CLOCK_tb = ~CLOCK_tb;

    // Log every DPRAM write; pixel i of a line carries data i+3.
    always begin
        @(posedge CLOCK_tb);
        #1;
        if (DPRAM_WE) begin
            wr_log[wr_total] = DPRAM_WR_ADDR;
            if (DPRAM_WR_DATA !== ({1'b0, DPRAM_WR_ADDR[A_W-1:0]} + 10'd3))
                bad_data++;
            wr_total++;
        end
        if (LINE_FINISHED)
            commit_total++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at a falling edge; returns at the next
    // falling edge, where outputs reflect these inputs.
    task automatic cyc(input logic p, input logic [D_W-1:0] d, input logic e,
                       input logic ls, input logic fs, input logic rd);
        PULSE       = p;
        PIXEL_DATA  = d;
        PIXEL_ERROR = e;
        LINE_SYNC   = ls;
        FRAME_SYNC  = fs;
        RD_DONE     = rd;
        @(negedge CLOCK_tb);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pixels(input int n, input int err_idx);
        for (int i = 0; i < n; i++)
            cyc(1'b1, D_W'(i + 3), (i == err_idx), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic close_line(input logic rd);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, rd);
    endtask

    initial begin
        RESET = 1'b1;
        PULSE = 1'b0; PIXEL_DATA = '0; PIXEL_ERROR = 1'b0;
        LINE_SYNC = 1'b0; FRAME_SYNC = 1'b0; RD_DONE = 1'b0;
        repeat (3) @(negedge CLOCK_tb);

        check_val("rst_we",   DPRAM_WE, 0);
        check_val("rst_addr", DPRAM_WR_ADDR, 0);
        check_val("rst_data", DPRAM_WR_DATA, 0);
        check_val("rst_fin",  LINE_FINISHED, 0);
        check_val("rst_len",  LINE_LEN, 0);
        check_val("rst_ovf",  OVERFLOW, 0);
        check_val("rst_occ",  OCCUPANCY, 0);
        RESET = 1'b0;

        // Before any FRAME_SYNC, pixels and line syncs are ignored.
        send_pixels(5, -1);
        close_line(1'b0);
        idle();
        check_val("wait_writes",  wr_total, 0);
        check_val("wait_commits", commit_total, 0);

        // Clean 250-pixel line into page 0.
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        base = wr_total;
        send_pixels(250, -1);
        close_line(1'b0);
        check_val("l0_fin",   LINE_FINISHED, 1);
        check_val("l0_page",  LINE_PAGE, 0);
        check_val("l0_len",   LINE_LEN, 250);
        check_val("l0_err",   LINE_ERR, 0);
        check_val("l0_occ",   OCCUPANCY, 1);
        check_val("l0_nwr",   wr_total - base, 250);
        check_val("l0_first", wr_log[base], 0);
        check_val("l0_last",  wr_log[wr_total-1], 249);
        idle();
        check_val("l0_fin_pulse", LINE_FINISHED, 0);

        // 249 pixels, error on pixel 10, into page 1.
        base = wr_total;
        send_pixels(249, 10);
        close_line(1'b0);
        check_val("l1_len",   LINE_LEN, 249);
        check_val("l1_err",   LINE_ERR, 1);
        check_val("l1_page",  LINE_PAGE, 1);
        check_val("l1_first", wr_log[base], 512);
        check_val("l1_occ",   OCCUPANCY, 2);

        // Commit and release in the same cycle at occupancy 2.
        send_pixels(250, -1);
        close_line(1'b1);
        check_val("l2_fin",  LINE_FINISHED, 1);
        check_val("l2_page", LINE_PAGE, 2);
        check_val("l2_occ",  OCCUPANCY, 2);

        // Reset in the middle of a line.
        send_pixels(100, -1);
        RESET = 1'b1;
        cyc(1'b1, 10'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("mrst_we",   DPRAM_WE, 0);
        check_val("mrst_addr", DPRAM_WR_ADDR, 0);
        check_val("mrst_len",  LINE_LEN, 0);
        check_val("mrst_page", LINE_PAGE, 0);
        check_val("mrst_occ",  OCCUPANCY, 0);
        RESET = 1'b0;
        idle();

        // Fill all four pages.
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send_pixels(250, -1);
            close_line(1'b0);
            check_val("fill_page", LINE_PAGE, k);
        end
        check_val("fill_occ", OCCUPANCY, 4);

        // Fifth line is dropped.
        base  = wr_total;
        cbase = commit_total;
        send_pixels(250, -1);
        close_line(1'b0);
        check_val("drop_ovf", OVERFLOW, 1);
        check_val("drop_fin", LINE_FINISHED, 0);
        check_val("drop_nwr", wr_total - base, 0);
        idle();
        check_val("drop_ovf_pulse", OVERFLOW, 0);
        check_val("drop_ncommit", commit_total - cbase, 0);

        // Release one page, sixth line lands on page 0.
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("rd_occ", OCCUPANCY, 3);
        send_pixels(250, -1);
        close_line(1'b0);
        check_val("l6_fin",  LINE_FINISHED, 1);
        check_val("l6_page", LINE_PAGE, 0);
        check_val("l6_occ",  OCCUPANCY, 4);

        // Drain, then a release at zero is ignored.
        repeat (4) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("drain_occ", OCCUPANCY, 0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("rd_at_zero", OCCUPANCY, 0);

        // 600-pixel line overruns page 1.
        base = wr_total;
        send_pixels(600, -1);
        close_line(1'b0);
        check_val("ovr_len",   LINE_LEN, 512);
        check_val("ovr_err",   LINE_ERR, 1);
        check_val("ovr_page",  LINE_PAGE, 1);
        check_val("ovr_nwr",   wr_total - base, 512);
        check_val("ovr_first", wr_log[base], 512);
        check_val("ovr_last",  wr_log[wr_total-1], 1023);

        // Partial line discarded by FRAME_SYNC (with a pixel that same cycle),
        // then a line whose last pixel coincides with LINE_SYNC.
        base  = wr_total;
        cbase = commit_total;
        send_pixels(100, -1);
        cyc(1'b1, 10'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("fs_nwr", wr_total - base, 100);
        base = wr_total;
        send_pixels(249, -1);
        cyc(1'b1, 10'(249 + 3), 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("fs_fin",     LINE_FINISHED, 1);
        check_val("fs_len",     LINE_LEN, 250);
        check_val("fs_err",     LINE_ERR, 0);
        check_val("fs_page",    LINE_PAGE, 2);
        check_val("fs_nwr2",    wr_total - base, 250);
        check_val("fs_first",   wr_log[base], 1024);
        check_val("fs_last",    wr_log[wr_total-1], 1024 + 249);
        check_val("fs_ncommit", commit_total - cbase, 1);
        idle();
        check_val("wr_data", bad_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_line_buf_wr_ctrl
`default_nettype wire

// File: doc/line_buf_wr_ctrl.md
# line_buf_wr_ctrl

Parametrised multi-page line-buffer write controller for the NanEye receive path. It sits between the RX deserializer's parallel pixel output and the line DPRAM, and supersedes the fixed two-page write controller. Each line goes into one of 2^C_PAGE_W pages, and each committed line is reported with its length and an error flag. Pages are released by the read side, and a line arriving while every page is occupied is dropped and flagged.

## Interface
- C_ADDR_W, 9: pixel address width within a page; page capacity 2^C_ADDR_W pixels
- C_PAGE_W, 1: page index width; C_PAGES = 2^C_PAGE_W (1..4 supported)
- C_DATA_W, 10: pixel data width written to DPRAM
- C_LINE_LEN, 250: expected pixels per line; 0 disables the length check
- CLOCK  in  1  sampling clock; single clock domain, all logic on rising edge
- RESET  in  1  synchronous, active-high
- PULSE  in  1  pixel valid strobe, one cycle per pixel
- PIXEL_DATA  in  C_DATA_W  pixel, valid with PULSE
- PIXEL_ERROR  in  1  current pixel corrupt, valid with PULSE
- LINE_SYNC  in  1  end-of-line pulse
- FRAME_SYNC  in  1  start-of-frame pulse
- RD_DONE  in  1  read side releases the oldest committed page, one pulse per page
- DPRAM_WR_ADDR  out  C_PAGE_W+C_ADDR_W  {page, pixel index}
- DPRAM_WR_DATA  out  C_DATA_W  registered PIXEL_DATA
- DPRAM_WE  out  1  write enable
- LINE_FINISHED  out  1  one-cycle commit pulse
- LINE_PAGE  out  C_PAGE_W  page of the committed line, valid with LINE_FINISHED
- LINE_LEN  out  C_ADDR_W+1  pixel count of the committed line, valid with LINE_FINISHED
- LINE_ERR  out  1  committed line had PIXEL_ERROR, a length mismatch or a page overrun
- OVERFLOW  out  1  one-cycle pulse when a line is dropped
- OCCUPANCY  out  C_PAGE_W+1  committed, unreleased pages

## Operation
- FSM states: WAIT_FRAME, ACTIVE, DROP. Reset enters WAIT_FRAME; PULSE and LINE_SYNC are ignored there.
- FRAME_SYNC in any state:
  - enter ACTIVE
  - clear pixel count and error flag
  - discard any partial line; no commit, wr_page unchanged
  - OCCUPANCY unchanged
- ACTIVE, PULSE at pixel count 0 with OCCUPANCY = C_PAGES: enter DROP. No writes occur in DROP.
- ACTIVE, PULSE with pixel count < 2^C_ADDR_W:
  - write PIXEL_DATA to {wr_page, count}
  - count+1
  - error flag |= PIXEL_ERROR
- ACTIVE, PULSE with pixel count = 2^C_ADDR_W: not written; error flag set. The count saturates.
- ACTIVE, LINE_SYNC with count > 0: commit.
  - LINE_FINISHED = 1, LINE_PAGE = wr_page, LINE_LEN = count
  - LINE_ERR = flag | (C_LINE_LEN≠0 & count≠C_LINE_LEN)
  - wr_page+1 modulo C_PAGES, OCCUPANCY+1
  - clear count and flag
- ACTIVE, LINE_SYNC with count = 0: no effect.
- DROP, LINE_SYNC: OVERFLOW = 1; clear count and flag; return to ACTIVE.
- RD_DONE: OCCUPANCY-1. RD_DONE at OCCUPANCY = 0 is ignored.
- Commit and RD_DONE in the same cycle: OCCUPANCY unchanged.
- PULSE and LINE_SYNC in the same cycle: the pixel belongs to the line being closed. It is written and counted before the commit.
- PULSE and FRAME_SYNC in the same cycle: FRAME_SYNC wins; the pixel is discarded.

## Timing
- Reset values: all outputs 0; wr_page 0; state WAIT_FRAME.
- DPRAM_WE, DPRAM_WR_ADDR and DPRAM_WR_DATA are registered one cycle after PULSE.
- LINE_FINISHED, LINE_PAGE, LINE_LEN and LINE_ERR are registered one cycle after LINE_SYNC, and come no earlier than the last write of that line.
- OVERFLOW is registered one cycle after LINE_SYNC.
- OCCUPANCY updates one cycle after commit or RD_DONE.
- Back-to-back PULSE on every cycle is supported.
- A LINE_SYNC one cycle after the last PULSE commits the correct count.
- Reset mid-line discards everything: pages are lost and OCCUPANCY is 0.

## Structure
- A shared package holds:
  - FSM state encoding (WAIT_FRAME, ACTIVE, DROP)
  - function computing LINE_ERR
  - width constants derived from C_ADDR_W and C_PAGE_W
- One natural sub-module, line_page_ring: wr_page pointer and OCCUPANCY up/down counter, with inc, dec and full outputs.

## Test plan
- C_PAGE_W=1, C_LINE_LEN=250: FRAME_SYNC, then 250 clean PULSEs, then LINE_SYNC.
  - Writes go to addresses 0..249.
  - One cycle after LINE_SYNC: LINE_FINISHED=1, LINE_PAGE=0, LINE_LEN=250, LINE_ERR=0, OCCUPANCY=1.
- Same setup, 249 pixels with PIXEL_ERROR on pixel 10, then LINE_SYNC.
  - LINE_LEN=249, LINE_ERR=1, LINE_PAGE=1.
  - The write base address is 512.
- C_PAGE_W=2: commit 4 lines with no RD_DONE.
  - OCCUPANCY=4.
  - A 5th line produces no DPRAM_WE and OVERFLOW=1 after LINE_SYNC.
  - After RD_DONE, the 6th line commits to page 0.
- Commit and RD_DONE in the same cycle at OCCUPANCY=2: OCCUPANCY stays 2.
- Send 600 pixels with C_ADDR_W=9.
  - Only addresses 0..511 are written.
  - LINE_LEN=512, LINE_ERR=1.
- Send 100 pixels, then FRAME_SYNC, then 250 pixels and LINE_SYNC.
  - One commit only, LINE_LEN=250, on the same page the discarded partial line used.
  - Asserting RESET mid-line returns all outputs to 0 on the next cycle.
